// File: rtl/sn76489_pkg.sv
// sn76489_pkg: register map, PSG byte layout and writer FSM states shared by the bus writer.
package sn76489_pkg;

  localparam logic [2:0] FREQ1_REG         = 3'd0;
  localparam logic [2:0] FREQ3_REG         = 3'd1;
  localparam logic [2:0] FREQ2_REG         = 3'd2;
  localparam logic [2:0] NOISE_CONTROL_REG = 3'd3;
  localparam logic [2:0] ATT1_REG          = 3'd4;
  localparam logic [2:0] ATT3_REG          = 3'd5;
  localparam logic [2:0] ATT2_REG          = 3'd6;
  localparam logic [2:0] NOISE_ATT_REG     = 3'd7;

  // Byte layout on d[7:0]
  localparam int unsigned LATCH_FLAG_BIT = 0;
  localparam int unsigned REG_LSB        = 1;
  localparam int unsigned REG_MSB        = 3;
  localparam int unsigned NIBBLE_LSB     = 4;
  localparam int unsigned NIBBLE_MSB     = 7;
  localparam int unsigned DATA_LSB       = 2;
  localparam int unsigned DATA_MSB       = 7;
  localparam int unsigned NOISE_LSB      = 5;
  localparam int unsigned NOISE_MSB      = 7;

  // Queued request: {reg[2:0], value[9:0]}
  localparam int unsigned REQ_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_ACK,
    ST_RELEASE
  } writer_state_t;

  typedef struct packed {
    logic       two;
    logic [7:0] byte2;
    logic [7:0] byte1;
  } psg_bytes_t;

  // Map a register write onto one latch byte, plus a data byte for tone registers.
  function automatic psg_bytes_t encode_request(input logic [2:0] r, input logic [9:0] v);
    psg_bytes_t b;
    b = '0;
    b.byte1[LATCH_FLAG_BIT]   = 1'b1;
    b.byte1[REG_MSB:REG_LSB]  = r;
    case (r)
      FREQ1_REG, FREQ2_REG, FREQ3_REG: begin
        b.byte1[NIBBLE_MSB:NIBBLE_LSB] = v[9:6];
        b.byte2[DATA_MSB:DATA_LSB]     = v[5:0];
        b.two                          = 1'b1;
      end
      NOISE_CONTROL_REG: b.byte1[NOISE_MSB:NOISE_LSB] = v[2:0];
      ATT1_REG, ATT2_REG, ATT3_REG, NOISE_ATT_REG:
        b.byte1[NIBBLE_MSB:NIBBLE_LSB] = v[3:0];
      default: b.byte1[NIBBLE_MSB:NIBBLE_LSB] = v[3:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sn76489_req_fifo.sv
// sn76489_req_fifo: registered synchronous FIFO with full/empty flags and occupancy count.
module sn76489_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 13
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage, pointers and occupancy; cleared asynchronously on reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[PTR_W'(i)] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sn76489_bus_writer.sv
// sn76489_bus_writer: queues PSG register writes and plays them out on the SN76489 CPU bus.
module sn76489_bus_writer
  import sn76489_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_reg,
  input  logic [9:0] req_value,
  input  logic       psg_ready,
  output logic [7:0] d,
  output logic       nWE,
  output logic       nCE,
  output logic       busy,
  output logic       timeout_err
);
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  SETUP_LAST   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0]  HOLD_LAST    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES);

  writer_state_t    r_state, w_next_state;
  logic [7:0]       r_cnt, w_next_cnt;
  logic [7:0]       r_d, w_next_d;
  logic [7:0]       r_byte2, w_next_byte2;
  logic             r_second, w_next_second;
  logic             r_strobe_n;
  logic             r_busy;
  logic             r_timeout;
  logic             w_timeout;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [REQ_W-1:0] w_fifo_data;
  logic             w_nonempty_next;
  psg_bytes_t       w_enc;

  assign req_ready   = !w_full;
  assign w_push      = req_valid && !w_full;
  assign w_enc       = encode_request(w_fifo_data[12:10], w_fifo_data[9:0]);
  assign d           = r_d;
  assign nWE         = r_strobe_n;
  assign nCE         = r_strobe_n;
  assign busy        = r_busy;
  assign timeout_err = r_timeout;

  sn76489_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  ({req_reg, req_value}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // FIFO occupancy after this edge, so busy can be a flop yet track the queue exactly.
  always_comb begin
    w_nonempty_next = (w_count != '0);
    if (w_push && !w_pop)      w_nonempty_next = 1'b1;
    else if (w_pop && !w_push) w_nonempty_next = (w_count > CNT_W'(1));
  end

  // Next state, shared wait/setup/hold counter and next values for the registered bus outputs.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt + 8'd1;
    w_next_d      = r_d;
    w_next_byte2  = r_byte2;
    w_next_second = r_second;
    w_timeout     = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_cnt = '0;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_next_d      = w_enc.byte1;
          w_next_byte2  = w_enc.byte2;
          w_next_second = w_enc.two;
          w_next_state  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_next_cnt   = '0;
          w_next_state = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (!psg_ready) begin
          w_next_cnt   = '0;
          w_next_state = ST_ACK;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next_cnt    = '0;
          w_timeout     = 1'b1;
          w_next_second = 1'b0;
          w_next_state  = ST_RELEASE;
        end
      end
      ST_ACK: begin
        if (psg_ready) begin
          w_next_cnt   = '0;
          w_next_state = ST_RELEASE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_next_cnt    = '0;
          w_timeout     = 1'b1;
          w_next_second = 1'b0;
          w_next_state  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (r_cnt == HOLD_LAST) begin
          w_next_cnt = '0;
          if (r_second) begin
            w_next_d      = r_byte2;
            w_next_second = 1'b0;
            w_next_state  = ST_SETUP;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_next_cnt   = '0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus output flops; strobes and busy are registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_d        <= '0;
      r_byte2    <= '0;
      r_second   <= 1'b0;
      r_strobe_n <= 1'b1;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_d        <= w_next_d;
      r_byte2    <= w_next_byte2;
      r_second   <= w_next_second;
      r_strobe_n <= !((w_next_state == ST_STROBE) || (w_next_state == ST_ACK));
      r_busy     <= (w_next_state != ST_IDLE) || w_nonempty_next;
      r_timeout  <= w_timeout;
    end
  end

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// tb_sn76489_bus_writer: directed checks of the SN76489 bus writer against a behavioural PSG.
module tb_sn76489_bus_writer;
  import sn76489_pkg::*;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_reg;
  logic [9:0] req_value;
  logic       psg_ready;
  logic [7:0] d;
  logic       nWE;
  logic       nCE;
  logic       busy;
  logic       timeout_err;

  int total;
  int bad;

  sn76489_bus_writer #(
    .FIFO_DEPTH     (4),
    .SETUP_CYCLES   (2),
    .HOLD_CYCLES    (1),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_reg     (req_reg),
    .req_value   (req_value),
    .psg_ready   (psg_ready),
    .d           (d),
    .nWE         (nWE),
    .nCE         (nCE),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural PSG: captures a byte when the strobes fall, drops ready for psg_delay cycles.
  int unsigned psg_delay;
  bit          psg_stuck;
  int          psg_ph;
  int unsigned psg_cnt;
  logic [7:0]  wlog [$];
  logic [9:0]  m_freq [8];
  logic [3:0]  m_att [8];
  logic [2:0]  m_noise;
  logic [2:0]  m_latch;

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      psg_ready <= 1'b1;
      psg_ph    <= 0;
      psg_cnt   <= 0;
      m_latch   <= '0;
      m_noise   <= '0;
      for (int i = 0; i < 8; i++) begin
        m_freq[i] <= '0;
        m_att[i]  <= '0;
      end
    end else begin
      case (psg_ph)
        0: if (!nCE && !nWE) begin
          wlog.push_back(d);
          if (d[0]) begin
            m_latch <= d[3:1];
            case (d[3:1])
              3'd0, 3'd1, 3'd2: m_freq[d[3:1]][9:6] <= d[7:4];
              3'd3:             m_noise <= d[7:5];
              default:          m_att[d[3:1]] <= d[7:4];
            endcase
          end else begin
            m_freq[m_latch][5:0] <= d[7:2];
          end
          if (psg_stuck) begin
            psg_ph <= 2;
          end else begin
            psg_ready <= 1'b0;
            psg_cnt   <= psg_delay;
            psg_ph    <= 1;
          end
        end
        1: begin
          psg_cnt <= psg_cnt - 1;
          if (psg_cnt == 1) begin
            psg_ready <= 1'b1;
            psg_ph    <= 2;
          end
        end
        default: if (nCE) psg_ph <= 0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge and hold it until the writer accepts it.
  task automatic push(input logic [2:0] r, input logic [9:0] v, output int waited);
    waited    = 0;
    req_valid = 1'b1;
    req_reg   = r;
    req_value = v;
    while (req_ready !== 1'b1 && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    check("push_accept", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    while (nCE !== 1'b0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lo, w, k, base;
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_reg   = '0;
    req_value = '0;
    psg_delay = 31;
    psg_stuck = 1'b0;

    // Reset state
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_d", d, 8'h00);
    check("rst_nce", nCE, 1);
    check("rst_nwe", nWE, 1);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_ready", req_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Attenuation write: att1 = A, PSG holds ready low for 31 cycles
    psg_delay = 31;
    base = wlog.size();
    push(ATT1_REG, 10'h00A, w);
    wait_strobe(n);
    check("att_latency", n, 3);
    check("att_d", d, 8'hA9);
    lo = 0;
    while (nCE === 1'b0 && lo < 1000) begin
      lo++;
      @(negedge clock);
    end
    check("att_strobe_low", lo, 32);
    check("att_nwe_up", nWE, 1);
    check("att_d_hold", d, 8'hA9);
    wait_idle("att_idle");
    check("att_nbytes", wlog.size() - base, 1);
    check("att_psg", m_att[4], 4'hA);

    // Frequency write followed by an attenuation write; tone bytes stay adjacent
    psg_delay = 3;
    base = wlog.size();
    push(FREQ1_REG, 10'h3C5, w);
    push(ATT2_REG, 10'h003, w);
    wait_idle("freq_idle");
    check("freq_nbytes", wlog.size() - base, 3);
    check("freq_b1", wlog[base], 8'hF1);
    check("freq_b2", wlog[base+1], 8'h14);
    check("freq_b3", wlog[base+2], 8'h3D);
    check("freq_psg", m_freq[0], 10'h3C5);
    check("freq_att2", m_att[6], 4'h3);

    // Noise control
    base = wlog.size();
    push(NOISE_CONTROL_REG, 10'h005, w);
    wait_idle("noise_idle");
    check("noise_nbytes", wlog.size() - base, 1);
    check("noise_b", wlog[base], 8'hA7);
    check("noise_psg", m_noise, 3'b101);

    // FIFO full while the PSG stalls on an earlier byte
    psg_delay = 60;
    base = wlog.size();
    push(NOISE_ATT_REG, 10'h001, w);
    wait_strobe(n);
    push(ATT1_REG, 10'h001, w);
    check("full_w1", w, 0);
    push(ATT2_REG, 10'h002, w);
    push(ATT3_REG, 10'h003, w);
    push(NOISE_ATT_REG, 10'h004, w);
    check("full_w4", w, 0);
    check("full_ready_low", req_ready, 0);
    push(ATT1_REG, 10'h005, w);
    check("full_5th_waited", (w > 0), 1);
    check("full_5th_after_pop", wlog.size() - base, 1);
    wait_idle("full_idle");
    check("full_nbytes", wlog.size() - base, 6);
    check("full_b0", wlog[base],   8'h1F);
    check("full_b1", wlog[base+1], 8'h19);
    check("full_b2", wlog[base+2], 8'h2D);
    check("full_b3", wlog[base+3], 8'h3B);
    check("full_b4", wlog[base+4], 8'h4F);
    check("full_b5", wlog[base+5], 8'h59);

    // Timeout: PSG never acknowledges; pending tone data byte is dropped
    psg_stuck = 1'b1;
    base = wlog.size();
    push(FREQ2_REG, 10'h2AB, w);
    wait_strobe(n);
    k = 0;
    while (timeout_err !== 1'b1 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    check("to_cycles", k, 256);
    check("to_strobe_up", nCE, 1);
    @(negedge clock);
    check("to_pulse_one", timeout_err, 0);
    psg_stuck = 1'b0;
    wait_idle("to_idle");
    check("to_dropped", wlog.size() - base, 1);
    check("to_b1", wlog[base], 8'hA5);
    push(ATT3_REG, 10'h007, w);
    wait_idle("to_next_idle");
    check("to_next_nbytes", wlog.size() - base, 2);
    check("to_next_b", wlog[base+1], 8'h7B);
    check("to_next_psg", m_att[5], 4'h7);

    // Reset while the writer waits in ACK with a second request queued
    psg_delay = 50;
    base = wlog.size();
    push(FREQ3_REG, 10'h155, w);
    push(ATT1_REG, 10'h009, w);
    wait_strobe(n);
    repeat (3) @(negedge clock);
    check("mid_in_ack", nCE, 0);
    #2 reset = 1'b1;
    #1;
    check("mid_nce", nCE, 1);
    check("mid_nwe", nWE, 1);
    check("mid_d", d, 8'h00);
    check("mid_busy", busy, 0);
    check("mid_ready", req_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_stay_idle", busy, 0);
    check("mid_stay_nce", nCE, 1);
    check("mid_no_resume", wlog.size() - base, 1);
    psg_delay = 3;
    push(ATT2_REG, 10'h00C, w);
    wait_strobe(n);
    check("mid_next_latency", n, 3);
    check("mid_next_d", d, 8'hCD);
    wait_idle("mid_next_idle");
    check("mid_next_nbytes", wlog.size() - base, 2);
    check("mid_next_psg", m_att[6], 4'hC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
